// File: rtl/exc_ctrl.sv
// Exception/interrupt controller ahead of coprocessor 0: arbitrates overflow, reserved
// instruction, break and external interrupt, drives EPC/Cause strobes, flushes and redirects.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        int_en,
    input  logic        stall,
    input  logic        id_valid,
    input  logic        undef_id,
    input  logic        brk_id,
    input  logic        eret_id,
    input  logic        ovf_ex,
    input  logic [31:0] pc_id,
    input  logic [31:0] pc_ex,
    input  logic [31:0] epc_in,
    output logic        EPCWrite,
    output logic        CauseWrite,
    output logic [1:0]  IntCause,
    output logic [31:0] exc_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        in_handler
);

    typedef enum logic {
        IDLE,
        HANDLER
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_INT = 2'd0,
        CAUSE_BRK = 2'd1,
        CAUSE_RI  = 2'd2,
        CAUSE_OVF = 2'd3
    } cause_t;

    state_t                 state;
    state_t                 state_next;
    cause_t                 cause;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic                   irq_level_d;
    logic                   irq_rise;
    logic                   irq_pend;
    logic                   take_irq;
    logic                   take;
    logic                   id_ok;
    logic                   ev_ovf;
    logic                   ev_ri;
    logic                   ev_brk;
    logic                   ev_irq;
    logic                   eret_ok;

    assign irq_rise = irq_sync[SYNC_STAGES-1] & ~irq_level_d;

    // A pend survives arbitration losses and int_en being low; only a take or reset clears it.
    always_ff @(posedge CLK) begin
        if (rst) begin
            irq_sync    <= '0;
            irq_level_d <= 1'b0;
            irq_pend    <= 1'b0;
        end else begin
            irq_sync    <= {irq_sync[SYNC_STAGES-2:0], ext_irq};
            irq_level_d <= irq_sync[SYNC_STAGES-1];
            irq_pend    <= (irq_pend & ~take_irq) | irq_rise;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign id_ok   = id_valid & ~stall;
    assign ev_ovf  = ovf_ex;
    assign ev_ri   = undef_id & id_ok;
    assign ev_brk  = brk_id & id_ok;
    assign ev_irq  = irq_pend & int_en & (state == IDLE) & id_ok;
    assign take    = ev_ovf | ev_ri | ev_brk | ev_irq;
    assign eret_ok = eret_id & id_ok & (state == HANDLER) & ~take;

    // Fixed-priority arbitration: the older EX overflow beats any ID event, interrupts last.
    always_comb begin
        cause    = CAUSE_INT;
        take_irq = 1'b0;
        if (ev_ovf) begin
            cause = CAUSE_OVF;
        end else if (ev_ri) begin
            cause = CAUSE_RI;
        end else if (ev_brk) begin
            cause = CAUSE_BRK;
        end else if (ev_irq) begin
            cause    = CAUSE_INT;
            take_irq = 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        EPCWrite    = 1'b0;
        CauseWrite  = 1'b0;
        IntCause    = 2'd0;
        exc_pc      = 32'd0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if (!rst) begin
            if (take) begin
                state_next  = HANDLER;
                EPCWrite    = 1'b1;
                CauseWrite  = 1'b1;
                IntCause    = cause;
                exc_pc      = ev_ovf ? pc_ex : pc_id;
                flush_if    = 1'b1;
                flush_id    = 1'b1;
                flush_ex    = ev_ovf;
                redirect    = 1'b1;
                redirect_pc = EXC_VECTOR;
            end else if (eret_ok) begin
                state_next  = IDLE;
                flush_if    = 1'b1;
                flush_id    = 1'b1;
                redirect    = 1'b1;
                redirect_pc = epc_in;
            end
        end
    end

    assign in_handler = (state == HANDLER) & ~rst;

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller for the pipelined MIPS core. It sits directly upstream of coprocessor 0 and detects arithmetic overflow, reserved instructions, breakpoints and external interrupts. It prioritises them and drives the coprocessor's EPC/Cause write strobes, cause code and captured PC. It also flushes the pipeline, redirects fetch to the handler vector, and returns to the saved EPC on `eret`.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h8000_0180, handler entry address.
- `SYNC_STAGES`, 2, flip-flop depth of the `ext_irq` synchroniser (≥2).

Ports (one clock `CLK`; reset `rst` is synchronous and active-high):
- `CLK` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `ext_irq` in 1: asynchronous level interrupt request.
- `int_en` in 1: global interrupt enable.
- `stall` in 1: IF/ID frozen this cycle.
- `id_valid` in 1: ID holds a real instruction, not a bubble.
- `undef_id` in 1: ID instruction is reserved/undefined.
- `brk_id` in 1: ID instruction is `break`.
- `eret_id` in 1: ID instruction is `eret`.
- `ovf_ex` in 1: EX instruction overflowed.
- `pc_id` in 32: PC of the ID instruction.
- `pc_ex` in 32: PC of the EX instruction.
- `epc_in` in 32: current EPC read back from coprocessor 0.
- `EPCWrite` out 1: capture `exc_pc` into EPC.
- `CauseWrite` out 1: write Cause from `IntCause`.
- `IntCause` out 2: 0 = interrupt, 1 = breakpoint, 2 = reserved instruction, 3 = overflow.
- `exc_pc` out 32: PC to be saved.
- `flush_if`, `flush_id`, `flush_ex` out 1 each: squash stage contents.
- `redirect` out 1: override next PC.
- `redirect_pc` out 32: target when `redirect` = 1.
- `in_handler` out 1: state is HANDLER.

## Operation
- States:
  - IDLE: normal execution.
  - HANDLER: between exception entry and `eret`.
- Interrupt path:
  - `ext_irq` passes through a `SYNC_STAGES` synchroniser.
  - A rising edge on the synchronised level sets `irq_pend`.
  - `irq_pend` clears only when the interrupt is taken or on `rst`.
- Priority, evaluated combinationally each cycle:
  1. `ovf_ex`: always eligible, because the EX instruction is older.
  2. `undef_id`, then `brk_id`: eligible only if `id_valid & ~stall`.
  3. Interrupt: eligible only if `irq_pend & int_en & state==IDLE & id_valid & ~stall`.
- Take cycle, when any event is eligible:
  - `EPCWrite = CauseWrite = 1`; `IntCause` is per the winning event.
  - `exc_pc` = `pc_ex` for overflow, else `pc_id`.
  - `flush_if = flush_id = 1`. `flush_ex = 1` only for overflow. Note that ID faults and the interrupt do not flush EX: the older EX instruction completes.
  - `redirect = 1`, `redirect_pc = EXC_VECTOR`.
  - Next state is HANDLER.
- Synchronous exceptions are taken in HANDLER too (re-entry overwrites EPC). Interrupts are never taken in HANDLER.
- `eret`:
  - Condition: `eret_id & id_valid & ~stall & state==HANDLER` and no eligible exception.
  - Response: `redirect = 1`, `redirect_pc = epc_in`, `flush_if = 1`, `flush_id = 1`; next state is IDLE.
  - `eret` in IDLE is a no-op.
- Non-take, non-eret cycles: all strobes 0, `exc_pc` = 0, `redirect_pc` = 0, `IntCause` = 0.

## Timing
- Reset:
  - Asserting `rst` forces state to IDLE and clears `irq_pend` and all synchroniser flops.
  - Reset takes effect at the next edge, including mid-handler.
  - While `rst` = 1, every output is 0.
- Latency:
  - Strobes, flushes and redirect are combinational in the detection cycle N, and coprocessor 0 captures at the end of N.
  - `in_handler` rises in cycle N+1.
- `ext_irq` to earliest take: `SYNC_STAGES` + 1 edges, provided the other conditions hold.
- Strobes are one cycle wide per event. A held `undef_id` under `stall` produces no strobe until `stall` falls.
- Simultaneous events:
  - `ovf_ex` with any ID event: overflow wins. The ID event is flushed and not recorded.
  - A pending IRQ that loses arbitration stays pending.
  - Exception and `eret` in the same cycle: the exception wins and the state stays HANDLER.
- `int_en` falling while `irq_pend` = 1: the pend is retained and taken when `int_en` rises.

## Test plan
- Reset then idle: `rst` high for 2 cycles, then low for 5 → all outputs 0, `in_handler` = 0.
- Overflow: `ovf_ex` = 1 with `pc_ex` = 0x0040_0010 → same cycle `EPCWrite`, `CauseWrite`, `IntCause` = 3, `exc_pc` = 0x0040_0010, all three flushes, `redirect_pc` = 0x8000_0180; `in_handler` = 1 next cycle.
- Interrupt:
  - Stimulus: `ext_irq` pulse, `int_en` = 1, `id_valid` = 1, `pc_id` = 0x0040_0020.
  - Response: take on edge 3 after the pulse with `IntCause` = 0 and `exc_pc` = 0x0040_0020, `flush_ex` = 0.
  - A second pulse while in HANDLER stays pending until after `eret`.
- Priority: `ovf_ex` and `undef_id` together (`pc_ex` = 0x0040_0008, `pc_id` = 0x0040_000C) → `IntCause` = 3 and `exc_pc` = 0x0040_0008, single strobe.
- `eret` return: in HANDLER, `eret_id` = 1 with `epc_in` = 0x0040_0020 → `redirect_pc` = 0x0040_0020, `flush_if`/`flush_id` = 1, `in_handler` = 0 next cycle. `eret` in IDLE → no outputs.
- Stall and reset mid-handler:
  - `undef_id` held with `stall` = 1 for 3 cycles → no strobe; strobe appears in the cycle `stall` drops.
  - `rst` during HANDLER with `irq_pend` = 1 → IDLE, pend cleared, no later interrupt.
